// File: rtl/bash_line_port.sv
`timescale 1ns/1ps
// Terminal-side endpoint of the bash line interface: line editing with echo, line hand-off, reply printing.
// Optional "$ " prompt after reset and after each reply is enabled by defining BASH_PROMPT_EN.
module bash_line_port #(
   parameter int unsigned LINE_MAX = 32,
   parameter logic [7:0]  NEWLINE  = 8'h0A
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] key_data,
   input  logic       key_valid,
   output logic       key_ready,
   output logic [7:0] char_data,
   output logic       char_valid,
   input  logic       char_ready,
   output logic       out_newASCII_ready,
   output logic [5:0] out_lineLen,
   output logic [7:0] lineOut,
   input  logic       lineOut_nextASCII,
   input  logic       in_newASCII_ready,
   input  logic [7:0] lineIn,
   output logic       lineIn_nextASCII,
   input  logic       in_solved,
   output logic       out_solved
);

   localparam int unsigned AW = (LINE_MAX > 1) ? $clog2(LINE_MAX) : 1;

   typedef enum logic [2:0] {
`ifdef BASH_PROMPT_EN
      PROMPT,
`endif
      EDIT,
      ECHO,
      SEND,
      PRINT_FETCH,
      PRINT_WAIT,
      ACK,
      ACK_NL
   } state_t;

`ifdef BASH_PROMPT_EN
   localparam state_t IDLE_ST = PROMPT;
   logic prompt_sel_q;
`else
   localparam state_t IDLE_ST = EDIT;
`endif

   state_t     state_q, ret_q;
   logic [5:0] len_q, idx_q;
   logic [7:0] line_q [LINE_MAX];
   logic [7:0] char_data_q, line_out_q;
   logic       char_valid_q, nl_ready_q, lin_next_q, solved_q;
   logic       key_fire, key_eol, key_bs, has_room;

   assign key_ready = (state_q == EDIT) && !char_valid_q && !in_newASCII_ready;
   assign key_fire  = key_valid && key_ready;
   assign key_eol   = (key_data == 8'h0D) || (key_data == 8'h0A);
   assign key_bs    = (key_data == 8'h08);
   assign has_room  = (len_q < 6'(LINE_MAX));

   assign char_data          = char_data_q;
   assign char_valid         = char_valid_q;
   assign out_newASCII_ready = nl_ready_q;
   assign out_lineLen        = len_q;
   assign lineOut            = line_out_q;
   assign lineIn_nextASCII   = lin_next_q;
   assign out_solved         = solved_q;

   // Line storage carries no reset; len_q alone defines the valid contents.
   always_ff @(posedge clk) begin
      if (key_fire && !key_eol && !key_bs && has_room)
         line_q[AW'(len_q)] <= key_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE_ST;
         ret_q        <= EDIT;
         len_q        <= '0;
         idx_q        <= '0;
         char_data_q  <= '0;
         char_valid_q <= 1'b0;
         line_out_q   <= '0;
         nl_ready_q   <= 1'b0;
         lin_next_q   <= 1'b0;
         solved_q     <= 1'b0;
`ifdef BASH_PROMPT_EN
         prompt_sel_q <= 1'b0;
`endif
      end else begin
         lin_next_q <= 1'b0;
         solved_q   <= 1'b0;
         if (char_valid_q && char_ready)
            char_valid_q <= 1'b0;

         case (state_q)
`ifdef BASH_PROMPT_EN
            PROMPT: begin
               if (!char_valid_q) begin
                  char_data_q  <= prompt_sel_q ? 8'h20 : 8'h24;
                  char_valid_q <= 1'b1;
                  prompt_sel_q <= !prompt_sel_q;
                  if (prompt_sel_q) begin
                     ret_q   <= EDIT;
                     state_q <= ECHO;
                  end
               end
            end
`endif
            EDIT: begin
               // A pending reply pre-empts key acceptance (key_ready is low).
               if (in_newASCII_ready) begin
                  state_q <= PRINT_FETCH;
               end else if (key_fire) begin
                  if (key_eol) begin
                     char_data_q  <= NEWLINE;
                     char_valid_q <= 1'b1;
                     ret_q        <= SEND;
                     state_q      <= ECHO;
                  end else if (key_bs) begin
                     if (len_q != 6'd0) begin
                        len_q        <= len_q - 6'd1;
                        char_data_q  <= 8'h08;
                        char_valid_q <= 1'b1;
                     end
                  end else if (has_room) begin
                     len_q        <= len_q + 6'd1;
                     char_data_q  <= key_data;
                     char_valid_q <= 1'b1;
                  end
               end
            end
            ECHO: begin
               if (!char_valid_q) begin
                  state_q <= ret_q;
                  if (ret_q == SEND) begin
                     nl_ready_q <= 1'b1;
                     idx_q      <= '0;
                     line_out_q <= (len_q != 6'd0) ? line_q[0] : 8'h00;
                  end
               end
            end
            SEND: begin
               if (lineOut_nextASCII) begin
                  if (idx_q < len_q) begin
                     idx_q      <= idx_q + 6'd1;
                     line_out_q <= ((idx_q + 6'd1) < len_q) ? line_q[AW'(idx_q + 6'd1)] : 8'h00;
                  end else begin
                     nl_ready_q <= 1'b0;
                     idx_q      <= '0;
                     len_q      <= '0;
                     line_out_q <= '0;
                     state_q    <= EDIT;
                  end
               end
            end
            PRINT_FETCH: begin
               if (in_solved) begin
                  solved_q <= 1'b1;
                  state_q  <= ACK;
               end else if ((lineIn != 8'h00) && in_newASCII_ready && !char_valid_q) begin
                  char_data_q  <= lineIn;
                  char_valid_q <= 1'b1;
                  lin_next_q   <= 1'b1;
                  state_q      <= PRINT_WAIT;
               end
            end
            PRINT_WAIT: begin
               if (char_valid_q && char_ready)
                  state_q <= PRINT_FETCH;
            end
            ACK: begin
               state_q <= ACK_NL;
            end
            ACK_NL: begin
               if (!in_solved && !char_valid_q) begin
                  char_data_q  <= NEWLINE;
                  char_valid_q <= 1'b1;
                  ret_q        <= IDLE_ST;
                  state_q      <= ECHO;
               end
            end
            default: state_q <= EDIT;
         endcase
      end
   end

endmodule
